ifq_fetch_sched: RTL and testbench

Fetch scheduler for the instruction fetch queue.
- Issues line requests to the instruction cache and unpacks each returned line into the instruction FIFO, one word per cycle.
- Tracks FIFO occupancy internally, so a request is only issued when a whole line fits.
- Handles branch redirects: aborts any outstanding request, flushes the FIFO and restarts fetch at the branch target, including mid-line targets.

---
 rtl/ifq_pkg.sv | 29 ++
 rtl/ifq_occ_counter.sv | 47 ++++
 rtl/ifq_fetch_sched.sv | 134 +++++++++++++
 tb/tb_ifq_fetch_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ifq_pkg
// Brief   : Shared types and default geometry for the fetch scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package ifq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_UNPACK = 2'd2,
        ST_FLUSH  = 2'd3
    } ifq_state_e;

    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int WORD_SEL_W     = $clog2(DEF_LINE_WORDS);
    localparam int CNT_W          = $clog2(DEF_FIFO_DEPTH + 1);
    localparam int LINE_BYTES     = DEF_LINE_WORDS * 4;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_occ_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ifq_occ_counter
// Brief   : Instruction FIFO occupancy counter with free-space output.
// Revision: 1.0 - initial release
// ============================================================================
module ifq_occ_counter
    import ifq_pkg::*;
#(
    parameter int DEPTH   = DEF_FIFO_DEPTH,
    parameter int COUNT_W = CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] free
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else begin
            count_d = count_q + COUNT_W'(push) - COUNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign free  = COUNT_W'(DEPTH) - count_q;

endmodule
`default_nettype wire

// File: rtl/ifq_fetch_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ifq_fetch_sched
// Brief   : Issues cache line requests, unpacks lines into the instruction
//           FIFO and handles branch redirects with flush.
// Revision: 1.0 - initial release
// ============================================================================
module ifq_fetch_sched
    import ifq_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                LINE_WORDS = DEF_LINE_WORDS,
    parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                branch_valid,
    input  logic [ADDR_W-1:0]                   branch_target,
    input  logic                                rd_enable,
    input  logic                                cache_ack,
    output logic                                cache_rd_req,
    output logic [ADDR_W-1:0]                   cache_addr,
    output logic                                cache_abort,
    output logic [$clog2(LINE_WORDS)-1:0]       word_sel,
    output logic                                push_fifo,
    output logic                                pop_fifo,
    output logic                                flush_fifo,
    output logic                                line_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

    localparam int SEL_W = $clog2(LINE_WORDS);
    localparam int OFF_W = SEL_W + 2;
    localparam int HI_W  = ADDR_W - OFF_W;
    localparam int CW    = cnt_width(FIFO_DEPTH);

    ifq_state_e       state_q,     state_d;
    logic [HI_W-1:0]  line_hi_q,   line_hi_d;
    logic [SEL_W-1:0] start_off_q, start_off_d;
    logic [SEL_W-1:0] word_sel_q,  word_sel_d;

    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_free;
    logic             w_last;
    logic             w_unused_tgt_lsb;

    // The fetch PC is kept split as line base plus word offset within the line.
    assign w_last           = (word_sel_q == SEL_W'(LINE_WORDS - 1));
    assign w_unused_tgt_lsb = ^branch_target[1:0];

    always_comb begin
        cache_rd_req = (state_q == ST_REQ);
        cache_addr   = {line_hi_q, {OFF_W{1'b0}}};
        cache_abort  = branch_valid && (state_q == ST_REQ);
        push_fifo    = (state_q == ST_UNPACK) && !branch_valid;
        line_done    = (state_q == ST_UNPACK) && !branch_valid && w_last;
        flush_fifo   = (state_q == ST_FLUSH);
        pop_fifo     = rd_enable && (w_count != '0) && (state_q != ST_FLUSH) && !branch_valid;
    end

    assign word_sel   = word_sel_q;
    assign fifo_count = w_count;

    always_comb begin
        state_d     = state_q;
        line_hi_d   = line_hi_q;
        start_off_d = start_off_q;
        word_sel_d  = word_sel_q;
        if (branch_valid) begin
            line_hi_d   = branch_target[ADDR_W-1:OFF_W];
            start_off_d = branch_target[OFF_W-1:2];
            state_d     = ST_FLUSH;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (w_free >= CW'(LINE_WORDS)) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (cache_ack) begin
                        word_sel_d = start_off_q;
                        state_d    = ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    word_sel_d = word_sel_q + SEL_W'(1);
                    if (w_last) begin
                        line_hi_d   = line_hi_q + HI_W'(1);
                        start_off_d = '0;
                        state_d     = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            line_hi_q   <= RESET_PC[ADDR_W-1:OFF_W];
            start_off_q <= RESET_PC[OFF_W-1:2];
            word_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            line_hi_q   <= line_hi_d;
            start_off_q <= start_off_d;
            word_sel_q  <= word_sel_d;
        end
    end

    ifq_occ_counter #(
        .DEPTH   (FIFO_DEPTH),
        .COUNT_W (CW)
    ) u_occ (
        .clk   (clk),
        .reset (reset),
        .push  (push_fifo),
        .pop   (pop_fifo),
        .clear (flush_fifo),
        .count (w_count),
        .free  (w_free)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifq_fetch_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_ifq_fetch_sched
// Brief   : Directed bench with a queue-based reference model for the fetch scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifq_fetch_sched;

    localparam int          LW    = 4;
    localparam int          DEPTH = 16;
    localparam int          LB    = LW * 4;
    localparam logic [31:0] RPC   = 32'h100;

    localparam int P_IDLE = 0, P_REQ = 1, P_UNPACK = 2, P_FLUSH = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        rd_enable = 1'b0;
    logic        cache_ack = 1'b0;
    logic        cache_rd_req;
    logic [31:0] cache_addr;
    logic        cache_abort;
    logic [1:0]  word_sel;
    logic        push_fifo;
    logic        pop_fifo;
    logic        flush_fifo;
    logic        line_done;
    logic [4:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;
    int ack_delay = 2;
    int req_cyc = 0;

    ifq_fetch_sched #(
        .ADDR_W     (32),
        .LINE_WORDS (LW),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RPC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .rd_enable     (rd_enable),
        .cache_ack     (cache_ack),
        .cache_rd_req  (cache_rd_req),
        .cache_addr    (cache_addr),
        .cache_abort   (cache_abort),
        .word_sel      (word_sel),
        .push_fifo     (push_fifo),
        .pop_fifo      (pop_fifo),
        .flush_fifo    (flush_fifo),
        .line_done     (line_done),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue of fetched word addresses.
    int          m_ph   = P_IDLE;
    logic [31:0] m_base = RPC & ~32'(LB - 1);
    int          m_off  = int'((RPC >> 2) % LW);
    int          m_sel  = 0;
    logic [31:0] m_q[$];

    always @(negedge clk) begin : model
        bit e_req, e_abort, e_push, e_done, e_flush, e_pop;
        int pre;
        e_req   = (m_ph == P_REQ);
        e_abort = branch_valid && (m_ph == P_REQ);
        e_push  = (m_ph == P_UNPACK) && !branch_valid;
        e_done  = e_push && (m_sel == LW - 1);
        e_flush = (m_ph == P_FLUSH);
        e_pop   = rd_enable && (m_q.size() != 0) && (m_ph != P_FLUSH) && !branch_valid;
        chk("cyc_rd_req", cache_rd_req, e_req);
        chk("cyc_abort", cache_abort, e_abort);
        chk("cyc_push", push_fifo, e_push);
        chk("cyc_line_done", line_done, e_done);
        chk("cyc_flush", flush_fifo, e_flush);
        chk("cyc_pop", pop_fifo, e_pop);
        chk("cyc_count", fifo_count, m_q.size());
        if (e_req) chk("cyc_addr", cache_addr, m_base);
        if (m_ph == P_UNPACK) chk("cyc_word_sel", word_sel, m_sel);
        if (reset) begin
            m_ph   = P_IDLE;
            m_base = RPC & ~32'(LB - 1);
            m_off  = int'((RPC >> 2) % LW);
            m_sel  = 0;
            m_q.delete();
        end else begin
            pre = m_q.size();
            if (e_pop)  void'(m_q.pop_front());
            if (e_push) m_q.push_back(m_base + 32'(4 * m_sel));
            if (m_ph == P_FLUSH) m_q.delete();
            if (branch_valid) begin
                m_base = branch_target & ~32'(LB - 1);
                m_off  = int'((branch_target >> 2) % LW);
                m_ph   = P_FLUSH;
            end else begin
                case (m_ph)
                    P_IDLE:   if (DEPTH - pre >= LW) m_ph = P_REQ;
                    P_REQ:    if (cache_ack) begin m_sel = m_off; m_ph = P_UNPACK; end
                    P_UNPACK: begin
                        if (m_sel == LW - 1) begin
                            m_base = m_base + 32'(LB);
                            m_off  = 0;
                            m_ph   = P_IDLE;
                        end
                        m_sel = (m_sel + 1) % LW;
                    end
                    default:  m_ph = P_IDLE;
                endcase
            end
        end
    end

    // Event logs used by the hand-computed literal checks.
    logic [31:0] req_log[$];
    int          sel_log[$];
    int          ln_cnt = 0;
    bit          prev_req = 1'b0;

    always @(negedge clk) begin
        if (cache_rd_req && !prev_req) req_log.push_back(cache_addr);
        if (push_fifo) sel_log.push_back(int'(word_sel));
        if (line_done) ln_cnt++;
        prev_req = cache_rd_req;
    end

    // Advance one clock; the cache answers ack_delay cycles into each request.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cache_rd_req) begin
            req_cyc++;
            cache_ack = (req_cyc > ack_delay);
        end else begin
            req_cyc   = 0;
            cache_ack = 1'b0;
        end
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return cache_rd_req;
            1:       return push_fifo;
            default: return line_done;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sig(which)) begin
                hit = 1'b1;
                break;
            end
            tick();
            #2;
        end
        chk(name, hit, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        // Reset state
        repeat (2) tick();
        #2;
        chk("rst_rd_req", cache_rd_req, 1'b0);
        chk("rst_push", push_fifo, 1'b0);
        chk("rst_word_sel", word_sel, 2'd0);
        chk("rst_count", fifo_count, 5'd0);
        chk("rst_flush", flush_fifo, 1'b0);
        reset = 1'b0;

        // Fill: four lines from 0x100, no pops
        repeat (60) tick();
        #2;
        chk("fill_req_count", req_log.size(), 4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            chk("fill_req_addr", req_log[i], 32'h100 + 32'(16 * i));
        chk("fill_line_done", ln_cnt, 4);
        chk("fill_push_count", sel_log.size(), 16);
        for (int i = 0; i < sel_log.size(); i++)
            chk("fill_word_sel", sel_log[i], i % 4);
        chk("fill_count", fifo_count, 5'd16);
        chk("fill_no_req", cache_rd_req, 1'b0);

        // Three pops leave too little room; the fourth frees a line
        for (int i = 0; i < 3; i++) begin
            rd_enable = 1'b1;
            tick();
            rd_enable = 1'b0;
            tick();
        end
        #2;
        chk("pop3_count", fifo_count, 5'd13);
        repeat (4) tick();
        #2;
        chk("pop3_no_req", cache_rd_req, 1'b0);
        rd_enable = 1'b1;
        tick();
        rd_enable = 1'b0;
        #2;
        chk("pop4_count", fifo_count, 5'd12);
        chk("pop4_no_req_yet", cache_rd_req, 1'b0);
        tick();
        #2;
        chk("pop4_req", cache_rd_req, 1'b1);
        chk("pop4_addr", cache_addr, 32'h140);

        // Branch to 0x208 while a request is pending
        branch_valid  = 1'b1;
        branch_target = 32'h208;
        #1;
        chk("br_req_abort", cache_abort, 1'b1);
        tick();
        branch_valid = 1'b0;
        #2;
        chk("br_req_flush", flush_fifo, 1'b1);
        rd_enable = 1'b1;
        #1;
        chk("pop_in_flush", pop_fifo, 1'b0);
        tick();
        #2;
        chk("br_req_count", fifo_count, 5'd0);
        chk("pop_at_empty", pop_fifo, 1'b0);
        rd_enable = 1'b0;
        ack_delay = 0;
        s0 = sel_log.size();
        wait_for(0, 20, "wait_req_208");
        chk("br_req_addr", cache_addr, 32'h200);
        wait_for(2, 20, "wait_done_208");
        tick();
        #2;
        chk("br_req_count2", fifo_count, 5'd2);
        chk("br_req_pushes", sel_log.size() - s0, 2);
        if (sel_log.size() >= s0 + 2) begin
            chk("br_req_sel_a", sel_log[s0], 2);
            chk("br_req_sel_b", sel_log[s0+1], 3);
        end

        // Branch during the second unpack cycle of line 0x210
        wait_for(1, 20, "wait_push_210");
        chk("unp_first_sel", word_sel, 2'd0);
        tick();
        #2;
        branch_valid  = 1'b1;
        branch_target = 32'h344;
        #1;
        chk("unp_br_push", push_fifo, 1'b0);
        chk("unp_br_done", line_done, 1'b0);
        tick();
        branch_valid = 1'b0;
        #2;
        chk("unp_br_flush", flush_fifo, 1'b1);
        chk("unp_br_count", fifo_count, 5'd3);
        tick();
        #2;
        chk("unp_br_cleared", fifo_count, 5'd0);
        wait_for(0, 20, "wait_req_344");
        chk("unp_br_addr", cache_addr, 32'h340);
        wait_for(2, 20, "wait_done_344");
        tick();
        #2;
        chk("unp_br_count2", fifo_count, 5'd3);

        // Address wrap past the top of the space
        branch_valid  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_valid = 1'b0;
        #2;
        chk("wrap_flush", flush_fifo, 1'b1);
        wait_for(0, 20, "wait_req_top");
        chk("wrap_top_addr", cache_addr, 32'hFFFF_FFF0);
        wait_for(2, 20, "wait_done_top");
        chk("wrap_top_sel", word_sel, 2'd3);
        tick();
        #2;
        chk("wrap_count", fifo_count, 5'd1);
        wait_for(0, 20, "wait_req_zero");
        chk("wrap_zero_addr", cache_addr, 32'h0);

        // Reset in the middle of unpacking
        wait_for(1, 20, "wait_push_zero");
        tick();
        #2;
        chk("mid_rst_sel", word_sel, 2'd1);
        reset = 1'b1;
        tick();
        #2;
        chk("mid_rst_push", push_fifo, 1'b0);
        chk("mid_rst_count", fifo_count, 5'd0);
        chk("mid_rst_req", cache_rd_req, 1'b0);
        reset = 1'b0;
        tick();
        #2;
        chk("post_rst_req", cache_rd_req, 1'b1);
        chk("post_rst_addr", cache_addr, RPC);
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
